// File: rtl/nand_ctrl_pkg.sv
// Shared definitions for the NAND sweep controller.
//   state_e      : controller state encoding (IDLE, DRIVE, DONE)
//   A_BIT, B_BIT : which vector-index bit drives each NAND input
//   nand_expect  : reference NAND value for a given {b,a} vector
package nand_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int A_BIT = 0;
  localparam int B_BIT = 1;

  function automatic logic nand_expect(input logic [1:0] vec);
    return ~(vec[A_BIT] & vec[B_BIT]);
  endfunction

endpackage

// File: rtl/nand_hold_timer.sv
// Per-vector hold timer for the NAND sweep controller.
// Down-counter reloaded with HOLD_CYCLES-1; the terminal count marks the
// last cycle a vector is held, after which it reloads for the next vector.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   clr  : reload the counter (start of a sweep)
//   en   : count this cycle (controller is driving a vector)
//   last : high in the final hold cycle of the current vector
module nand_hold_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = en && (cnt_q == '0);

endmodule

// File: rtl/nand_sweep_ctrl.sv
// Self-checking sweep sequencer for a shared two-input NAND gate.
// A start pulse walks {b,a} through 0..3, holding each vector HOLD_CYCLES
// cycles, NUM_PASSES times, and counts mismatches of gate_y against NAND.
// Optional build macro NAND_SWEEP_STOP_ON_ERR_EN: the first mismatch ends
// the sweep; the failing vector stays on vec_idx during the done pulse.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : sweep request, honoured only in IDLE
//   gate_a, gate_b  : NAND inputs (vec_idx bits A_BIT / B_BIT)
//   gate_y          : NAND output, sampled on a vector's last hold cycle
//   busy, done      : sweep in progress / one-cycle end pulse
//   pass, err_cnt   : result of the last sweep (saturating count)
//   vec_idx         : current {b,a} vector
//
// state | meaning
// IDLE  | waiting for start; results of last sweep held
// DRIVE | applying vectors, sampling gate_y at end of each hold
// DONE  | one-cycle done pulse with final pass/err_cnt
module nand_sweep_ctrl
  import nand_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_PASSES  = 1,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       vec_idx
);

  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             tmr_clr, tmr_en, tmr_last;
  logic             mismatch;

  nand_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (tmr_last)
  );

  assign mismatch = (gate_y != nand_expect(vec_q));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = 2'd0;
          pcnt_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          tmr_clr = 1'b1;
        end
      end
      DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
          end
`ifdef NAND_SWEEP_STOP_ON_ERR_EN
          if (mismatch) begin
            state_d = DONE;
            pass_d  = 1'b0;
          end else
`endif
          if (vec_q != 2'd3) begin
            vec_d = vec_q + 2'd1;
          end else if (pcnt_q != PASS_LAST) begin
            vec_d  = 2'd0;
            pcnt_d = pcnt_q + PW'(1);
          end else begin
            // err_d already includes the final vector's sample
            state_d = DONE;
            vec_d   = 2'd0;
            pass_d  = (err_d == '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = 2'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      pcnt_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign busy    = (state_q == DRIVE);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_idx = vec_q;
  assign gate_a  = vec_q[A_BIT];
  assign gate_b  = vec_q[B_BIT];

endmodule

// File: tb/tb_nand_sweep_ctrl.sv
module tb_nand_sweep_ctrl;

  localparam int H1 = 2, NP1 = 1, EW1 = 4;
  localparam int H2 = 3, NP2 = 2, EW2 = 2;
`ifdef NAND_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, start1, ga1, gb1, gy1, busy1, done1, pass1;
  logic [EW1-1:0] err1;
  logic [1:0] vec1;
  logic rst2, start2, ga2, gb2, gy2, busy2, done2, pass2;
  logic [EW2-1:0] err2;
  logic [1:0] vec2;

  // gate_y as a function of the applied vector: bit v is the gate output for {b,a}=v
  logic [3:0] fy1 = 4'b0111;
  logic [3:0] fy2 = 4'b0111;
  assign gy1 = fy1[{gb1, ga1}];
  assign gy2 = fy2[{gb2, ga2}];

  nand_sweep_ctrl #(.HOLD_CYCLES(H1), .NUM_PASSES(NP1), .ERR_W(EW1)) dut (
    .clk(clk), .rst(rst1), .start(start1), .gate_a(ga1), .gate_b(gb1), .gate_y(gy1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .vec_idx(vec1)
  );

  nand_sweep_ctrl #(.HOLD_CYCLES(H2), .NUM_PASSES(NP2), .ERR_W(EW2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .gate_a(ga2), .gate_b(gb2), .gate_y(gy2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .vec_idx(vec2)
  );

  int cur_sel = 1;
  logic busy_s, done_s, pass_s;
  logic [3:0] err_s;
  logic [1:0] vec_s, gate_s;
  always_comb begin
    if (cur_sel == 2) begin
      busy_s = busy2; done_s = done2; pass_s = pass2;
      err_s = {2'b00, err2}; vec_s = vec2; gate_s = {gb2, ga2};
    end else begin
      busy_s = busy1; done_s = done1; pass_s = pass1;
      err_s = err1; vec_s = vec1; gate_s = {gb1, ga1};
    end
  end

  int checks = 0;
  int failures = 0;

  int obs_vec[$];
  int busy_len, done_cnt, gate_bad, busy_after, err_done, err_idle, vec_done;
  bit timeout, done_seen, pass_done, pass_idle;

  task automatic drive_start(input int sel, input logic v);
    if (sel == 2) start2 = v;
    else start1 = v;
  endtask

  // Reference: expected length, final count, pass and done-cycle vector for a fault table
  task automatic model(input int h, input int np, input int ew, input logic [3:0] fy,
                       output int len, output int err, output int pss, output int vdone);
    int cnt;
    int first;
    int emax;
    cnt = 0;
    first = -1;
    emax = (1 << ew) - 1;
    for (int v = 0; v < 4; v++) begin
      if (fy[v] != ((v == 3) ? 1'b0 : 1'b1)) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
    if (STOP && first >= 0) begin
      len = (first + 1) * h;
      err = 1;
      vdone = first;
    end else begin
      len = 4 * h * np;
      err = (cnt * np > emax) ? emax : cnt * np;
      vdone = 0;
    end
    pss = (err == 0) ? 1 : 0;
  endtask

  // Runs one sweep on the selected DUT and records what it observed; no judgement here
  task automatic run_sweep(input int sel, input bit poke);
    int c;
    cur_sel = sel;
    obs_vec.delete();
    busy_len = 0; done_cnt = 0; gate_bad = 0; busy_after = 0;
    drive_start(sel, 1'b1);
    @(negedge clk);
    drive_start(sel, 1'b0);
    c = 0;
    while (busy_s && c < 400) begin
      obs_vec.push_back(int'(vec_s));
      if (gate_s != vec_s) gate_bad++;
      if (done_s) done_cnt++;
      busy_len++;
      drive_start(sel, poke && (busy_len == 2));
      @(negedge clk);
      c++;
    end
    timeout = busy_s;
    done_seen = done_s;
    if (done_s) done_cnt++;
    err_done = int'(err_s);
    pass_done = pass_s;
    vec_done = int'(vec_s);
    drive_start(sel, poke);
    @(negedge clk);
    drive_start(sel, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (done_s) done_cnt++;
      if (busy_s) busy_after++;
      @(negedge clk);
    end
    err_idle = int'(err_s);
    pass_idle = pass_s;
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, pass1, err1, vec1, gb1, ga1} !== '0) begin
      failures++;
      $display("FAIL reset_dut1: got %b want all zero", {busy1, done1, pass1, err1, vec1, gb1, ga1});
    end
    checks++;
    if ({busy2, done2, pass2, err2, vec2, gb2, ga2} !== '0) begin
      failures++;
      $display("FAIL reset_dut2: got %b want all zero", {busy2, done2, pass2, err2, vec2, gb2, ga2});
    end
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweeps;
    int c_sel[$];
    logic [3:0] c_fy[$];
    bit c_poke[$];
    int h, np, ew, len, err, pss, vdone, bad;
    string nm;
    // directed: healthy, stuck-1, inverted, inverted+saturation, start pokes, stuck-0
    c_sel = '{1, 1, 1, 2, 1, 2, 1};
    c_fy  = '{4'b0111, 4'b1111, 4'b1000, 4'b1000, 4'b0111, 4'b0000, 4'b0000};
    c_poke = '{0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      c_sel.push_back(int'($urandom_range(1, 2)));
      c_fy.push_back(4'($urandom_range(0, 15)));
      c_poke.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < c_sel.size(); i++) begin
      nm = $sformatf("case%0d_sel%0d_fy%b", i, c_sel[i], c_fy[i]);
      h  = (c_sel[i] == 2) ? H2 : H1;
      np = (c_sel[i] == 2) ? NP2 : NP1;
      ew = (c_sel[i] == 2) ? EW2 : EW1;
      if (c_sel[i] == 2) fy2 = c_fy[i];
      else fy1 = c_fy[i];
      model(h, np, ew, c_fy[i], len, err, pss, vdone);
      run_sweep(c_sel[i], c_poke[i]);
      checks++;
      if (timeout !== 1'b0) begin
        failures++; $display("FAIL %s timeout: busy still high after 400 cycles", nm);
      end
      checks++;
      if (busy_len != len) begin
        failures++; $display("FAIL %s busy_len: got %0d want %0d", nm, busy_len, len);
      end
      checks++;
      if (done_seen !== 1'b1) begin
        failures++; $display("FAIL %s done_after_busy: got %b want 1", nm, done_seen);
      end
      checks++;
      if (done_cnt != 1) begin
        failures++; $display("FAIL %s done_count: got %0d want 1", nm, done_cnt);
      end
      checks++;
      if (busy_after != 0) begin
        failures++; $display("FAIL %s restart_after_done: got %0d busy cycles want 0", nm, busy_after);
      end
      checks++;
      if (err_done != err) begin
        failures++; $display("FAIL %s err_at_done: got %0d want %0d", nm, err_done, err);
      end
      checks++;
      if (int'(pass_done) != pss) begin
        failures++; $display("FAIL %s pass_at_done: got %0d want %0d", nm, pass_done, pss);
      end
      checks++;
      if (vec_done != vdone) begin
        failures++; $display("FAIL %s vec_at_done: got %0d want %0d", nm, vec_done, vdone);
      end
      checks++;
      if (err_idle != err || int'(pass_idle) != pss) begin
        failures++;
        $display("FAIL %s idle_hold: got err=%0d pass=%0d want err=%0d pass=%0d", nm, err_idle, pass_idle, err, pss);
      end
      checks++;
      if (gate_bad != 0) begin
        failures++; $display("FAIL %s gate_vs_vec: got %0d bad cycles want 0", nm, gate_bad);
      end
      bad = 0;
      for (int k = 0; k < obs_vec.size(); k++) begin
        if (obs_vec[k] != (k / h) % 4) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL %s vec_sequence: got %0d wrong cycles want 0", nm, bad);
      end
    end
  endtask

  task automatic test_reset_midsweep;
    int dcnt;
    fy1 = 4'b0111;
    cur_sel = 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1 || vec1 !== 2'd2) begin
      failures++; $display("FAIL midsweep_pre: got busy=%b vec=%0d want busy=1 vec=2", busy1, vec1);
    end
    dcnt = 0;
    rst1 = 1'b1;
    @(negedge clk);
    if (done1) dcnt++;
    checks++;
    if ({busy1, done1, pass1, err1, vec1, gb1, ga1} !== '0) begin
      failures++;
      $display("FAIL midsweep_reset: got %b want all zero", {busy1, done1, pass1, err1, vec1, gb1, ga1});
    end
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done1) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      failures++; $display("FAIL midsweep_no_done: got %0d done pulses want 0", dcnt);
    end
    run_sweep(1, 1'b0);
    checks++;
    if (busy_len != 4 * H1 * NP1 || done_cnt != 1 || err_done != 0 || pass_done !== 1'b1) begin
      failures++;
      $display("FAIL midsweep_clean_rerun: got len=%0d done=%0d err=%0d pass=%0d want len=%0d done=1 err=0 pass=1",
               busy_len, done_cnt, err_done, pass_done, 4 * H1 * NP1);
    end
  endtask

  initial begin
    test_reset();
    test_sweeps();
    test_reset_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nand_sweep_ctrl.md
Name: nand_sweep_ctrl

Overview:
Self-checking sequencer for a shared two-input NAND gate instance. On a start pulse it drives the gate inputs through all four input combinations, holding each for a programmable number of cycles, and compares the gate output against the expected NAND value. It reports busy, done, pass and an error count. It replaces free-running toggle stimulus with a controlled, repeatable sweep usable in silicon bring-up and in benches.

Parameters:
- HOLD_CYCLES, 2, cycles each input vector is held; legal values ≥1.
- NUM_PASSES, 1, full 4-vector sweeps per start; legal values ≥1.
- ERR_W, 4, width of the error counter.

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle request to begin a sweep; sampled only in IDLE.
- gate_a, output, 1, NAND input a; equals vec_idx[0].
- gate_b, output, 1, NAND input b; equals vec_idx[1].
- gate_y, input, 1, NAND output; treated as combinationally valid in the same cycle.
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse at sweep end.
- pass, output, 1, high if the last sweep had zero mismatches; held until the next start.
- err_cnt, output, ERR_W, saturating mismatch count for the last or current sweep.
- vec_idx, output, 2, current vector index {b,a}.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; gate_a=gate_b=0; vec_idx=0; busy=0; done=0; pass=0; err_cnt=0; hold and pass counters=0. Reset takes priority at every edge, including mid-sweep. It aborts the sweep with no done pulse.
- States: IDLE, DRIVE, DONE.
- IDLE: if start=1 at an edge, then next state=DRIVE, vec_idx=0, hold_cnt=0, pass_cnt=0, err_cnt=0, busy=1, pass=0. Otherwise hold.
- DRIVE:
  - hold_cnt increments each cycle.
  - At the edge where hold_cnt==HOLD_CYCLES-1, sample gate_y. Expected value is ~(gate_a&gate_b). On mismatch, err_cnt increments, saturating at 2^ERR_W-1.
  - At that same edge: if vec_idx≠3, vec_idx increments and hold_cnt resets to 0.
  - If vec_idx==3 and pass_cnt≠NUM_PASSES-1: vec_idx wraps to 0 and pass_cnt increments.
  - Otherwise: next state=DONE.
- Each vector therefore occupies exactly HOLD_CYCLES cycles. busy is high for exactly 4·HOLD_CYCLES·NUM_PASSES cycles.
- DONE (one cycle): done=1; busy=0; pass=(err_cnt==0), using the count including the final sample; gate_a=gate_b=0; vec_idx=0. Next state=IDLE.
- start while busy or in DONE: ignored. No queuing.
- The final-vector mismatch is counted before pass is evaluated.
- err_cnt and pass remain stable in IDLE until the next accepted start.

Optional Feature:
- Macro: NAND_SWEEP_STOP_ON_ERR_EN.
- Defined: the first mismatch ends the sweep at that sample edge and the controller goes to DONE the next cycle. err_cnt=1, pass=0, and vec_idx holds the failing vector during the done pulse.
- Undefined: the sweep always runs to completion and every mismatch is counted.

Decomposition:
- Shared package/header nand_ctrl_pkg holds:
  - state encodings (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2);
  - the vector bit mapping constants (A_BIT=0, B_BIT=1).
- One sub-module, nand_hold_timer: a parameterised HOLD_CYCLES counter with clear input and a last-cycle strobe output.
- Controller FSM, compare logic and counters stay in nand_sweep_ctrl.

Test Plan:
- Healthy NAND, HOLD_CYCLES=2, NUM_PASSES=1, start pulse → busy high 8 cycles, vec_idx sequence 0,0,1,1,2,2,3,3, done pulse on cycle 9, pass=1, err_cnt=0.
- gate_y stuck at 1 → mismatch only at vec 3 → err_cnt=1, pass=0.
- gate_y inverted, NUM_PASSES=1 → err_cnt=4. Same fault with ERR_W=2, NUM_PASSES=2 → 8 mismatches, err_cnt saturates at 3.
- start re-asserted during DRIVE and during DONE → no restart; sweep length unchanged; exactly one done pulse.
- rst asserted at cycle 5 of a sweep → next edge all outputs at reset values, no done pulse; a new start then runs a clean full sweep.
- With NAND_SWEEP_STOP_ON_ERR_EN defined and gate_y stuck at 0 → mismatch at vec 0 on cycle 2, done on cycle 3, err_cnt=1, vec_idx=0, pass=0.
